// File: rtl/ransac_nios_dpram.sv
// ---------------------------------------------------------------------------
// ransac_nios_dpram
//
// True dual-port on-chip memory shared by the NIOS data master (s1) and the
// RANSAC accelerator master (s2). Both Avalon-MM slave ports run on one clock
// and never stall. Each port has its own clock enable and its own
// READ_LATENCY-deep read pipeline with an explicit readdatavalid.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   word address width, depth = 2**ADDR_WIDTH
//   READ_LATENCY read command to data, in cycles (1..3)
//   INIT_FILE    power-up contents, handed to the vendor memory flow
//   CNT_WIDTH    width of the saturating collision counter
//
// Ports (x = 1, 2)
//   clk, reset_n          clock, asynchronous active-low reset
//   sx_address            word address
//   sx_byteenable         write lane enables
//   sx_chipselect         port select
//   sx_read / sx_write    commands (write wins when both are high)
//   sx_writedata          write data
//   sx_clken              port clock enable, low freezes the port
//   sx_readdata           read data
//   sx_readdatavalid      read data qualifier
//   collision_count       number of same-address dual writes (saturating)
//
// Behaviour notes
//   - Reads return the word as it was before any write on the same edge
//     (old data), for both same-port and cross-port traffic.
//   - On a same-address dual write each byte lane takes s1 data if s1 enables
//     it, otherwise s2 data if s2 enables it, otherwise keeps its value.
//   - Memory contents are never touched by reset.
// ---------------------------------------------------------------------------
module ransac_nios_dpram #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "ransac_nios_dpram.hex",
    parameter int    CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    input  logic                      s1_clken,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    input  logic                      s2_clken,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,

    output logic [CNT_WIDTH-1:0]      collision_count
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 2;

    // Saturating increment used by the collision counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (value == {CNT_WIDTH{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_WIDTH'(1);
        end
        return result;
    endfunction

    // Storage. Contents come from INIT_FILE at configuration time only.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Per-port views of the two slave ports, index 0 = s1, index 1 = s2.
    logic [ADDR_WIDTH-1:0]   addr_s   [NUM_PORTS];
    logic [NUM_LANES-1:0]    be_s     [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   wdata_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0]    clken_s;
    logic [NUM_PORTS-1:0]    wr_acc_s;
    logic [NUM_PORTS-1:0]    rd_acc_s;
    logic                    collide_s;

    // Read pipelines: stage 0 is loaded at the accept edge, the last stage
    // drives the port outputs.
    logic [DATA_WIDTH-1:0]   pipe_data_r [NUM_PORTS][READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld_r  [NUM_PORTS];

    logic [CNT_WIDTH-1:0]    cnt_r;

    // Command decode. A read that arrives together with a write is dropped.
    always_comb begin
        addr_s[0]   = s1_address;
        addr_s[1]   = s2_address;
        be_s[0]     = s1_byteenable;
        be_s[1]     = s2_byteenable;
        wdata_s[0]  = s1_writedata;
        wdata_s[1]  = s2_writedata;
        clken_s     = {s2_clken, s1_clken};
        wr_acc_s[0] = s1_chipselect & s1_write & s1_clken;
        wr_acc_s[1] = s2_chipselect & s2_write & s2_clken;
        rd_acc_s[0] = s1_chipselect & s1_read & ~s1_write & s1_clken;
        rd_acc_s[1] = s2_chipselect & s2_read & ~s2_write & s2_clken;
        collide_s   = wr_acc_s[0] & wr_acc_s[1] & (addr_s[0] == addr_s[1]);
    end

    // Byte-lane writes from both ports. s2 lanes are scheduled first and s1
    // lanes last, so on a same-address collision an s1-enabled lane overrides
    // s2 and an s2-only lane still lands; disabled lanes are left alone.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_LANES; b++) begin
            if (wr_acc_s[1] && be_s[1][b]) begin
                mem_r[addr_s[1]][b*8 +: 8] <= wdata_s[1][b*8 +: 8];
            end
            if (wr_acc_s[0] && be_s[0][b]) begin
                mem_r[addr_s[0]][b*8 +: 8] <= wdata_s[0][b*8 +: 8];
            end
        end
    end

    // Read pipelines. The memory is sampled with the pre-write value of the
    // current edge, which gives old-data read-during-write. A port with clken
    // low holds its whole chain so a pending result resumes later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pipe_vld_r[p] <= {READ_LATENCY{1'b0}};
                for (int i = 0; i < READ_LATENCY; i++) begin
                    pipe_data_r[p][i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (clken_s[p]) begin
                    pipe_data_r[p][0] <= mem_r[addr_s[p]];
                    pipe_vld_r[p][0]  <= rd_acc_s[p];
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        pipe_data_r[p][i] <= pipe_data_r[p][i-1];
                        pipe_vld_r[p][i]  <= pipe_vld_r[p][i-1];
                    end
                end
            end
        end
    end

    // Same-address dual-write counter, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (collide_s) begin
            cnt_r <= sat_inc(cnt_r);
        end
    end

    // Outputs come straight from the last pipeline stage. Valid is masked
    // while the port is frozen, because the stage will not advance at the
    // coming edge and will present the same result again once unfrozen.
    assign s1_readdata      = pipe_data_r[0][READ_LATENCY-1];
    assign s1_readdatavalid = pipe_vld_r[0][READ_LATENCY-1] & s1_clken;
    assign s2_readdata      = pipe_data_r[1][READ_LATENCY-1];
    assign s2_readdatavalid = pipe_vld_r[1][READ_LATENCY-1] & s2_clken;
    assign collision_count  = cnt_r;

endmodule

// File: tb/tb_ransac_nios_dpram.sv
// ---------------------------------------------------------------------------
// tb_ransac_nios_dpram
//
// Three instances driven by the same stimulus: READ_LATENCY 1 (with a 4-bit
// collision counter), 2 and 3. Directed steps with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ransac_nios_dpram;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;

    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_chipselect, s2_chipselect;
    logic          s1_read, s2_read;
    logic          s1_write, s2_write;
    logic [31:0]   s1_writedata, s2_writedata;
    logic          s1_clken, s2_clken;

    logic [31:0]   s1_rd  [3];
    logic          s1_rdv [3];
    logic [31:0]   s2_rd  [3];
    logic          s2_rdv [3];
    logic [3:0]    cc_u1;
    logic [15:0]   cc_u2, cc_u3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ransac_nios_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1),
                        .INIT_FILE(""), .CNT_WIDTH(4)) u1 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_clken(s1_clken),
        .s1_readdata(s1_rd[0]), .s1_readdatavalid(s1_rdv[0]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_clken(s2_clken),
        .s2_readdata(s2_rd[0]), .s2_readdatavalid(s2_rdv[0]),
        .collision_count(cc_u1));

    ransac_nios_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2),
                        .INIT_FILE(""), .CNT_WIDTH(16)) u2 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_clken(s1_clken),
        .s1_readdata(s1_rd[1]), .s1_readdatavalid(s1_rdv[1]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_clken(s2_clken),
        .s2_readdata(s2_rd[1]), .s2_readdatavalid(s2_rdv[1]),
        .collision_count(cc_u2));

    ransac_nios_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(3),
                        .INIT_FILE(""), .CNT_WIDTH(16)) u3 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_clken(s1_clken),
        .s1_readdata(s1_rd[2]), .s1_readdatavalid(s1_rdv[2]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_clken(s2_clken),
        .s2_readdata(s2_rd[2]), .s2_readdatavalid(s2_rdv[2]),
        .collision_count(cc_u3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_read = 1'b0;  s1_write = 1'b0;  s1_chipselect = 1'b1;  s1_clken = 1'b1;
        s2_read = 1'b0;  s2_write = 1'b0;  s2_chipselect = 1'b1;  s2_clken = 1'b1;
        s1_byteenable = 4'hF;  s2_byteenable = 4'hF;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] e1, input logic [15:0] e23);
        chk({tag, "_cc_u1"}, {28'h0, cc_u1}, {16'h0, e1});
        chk({tag, "_cc_u2"}, {16'h0, cc_u2}, {16'h0, e23});
        chk({tag, "_cc_u3"}, {16'h0, cc_u3}, {16'h0, e23});
    endtask

    task automatic check_quiet(input string tag, input logic check_data);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_u%0d_s1vld", tag, d + 1), {31'h0, s1_rdv[d]}, 32'h0);
            chk($sformatf("%s_u%0d_s2vld", tag, d + 1), {31'h0, s2_rdv[d]}, 32'h0);
            if (check_data) begin
                chk($sformatf("%s_u%0d_s1data", tag, d + 1), s1_rd[d], 32'h0);
                chk($sformatf("%s_u%0d_s2data", tag, d + 1), s2_rd[d], 32'h0);
            end
        end
    endtask

    // Issue an s2 read (any write commands already set up go on the same
    // edge) and check the valid pulse lands after exactly 1/2/3 cycles.
    task automatic s2_read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        s2_address = a;
        s2_read    = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            cyc();
            if (s == 1) idle();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s_u%0d_vld_c%0d", tag, d + 1, s), {31'h0, s2_rdv[d]},
                    {31'h0, (s == d + 1)});
                if (s == d + 1) chk($sformatf("%s_u%0d_data", tag, d + 1), s2_rd[d], exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        s1_address = '0;  s2_address = '0;
        s1_writedata = 32'h0;  s2_writedata = 32'h0;
        idle();

        // Reset state
        cyc();
        cyc();
        check_quiet("reset", 1'b1);
        check_counts("reset", 16'h0, 16'h0);
        reset_n = 1'b1;
        cyc();

        // Preload: dual writes to different addresses (no collision)
        s1_address = 10'h100; s1_writedata = 32'h00000000; s1_write = 1'b1;
        s2_address = 10'h020; s2_writedata = 32'hFFFFFFFF; s2_write = 1'b1;
        cyc();
        s1_address = 10'h010; s1_writedata = 32'hDEADBEEF;
        s2_address = 10'h030; s2_writedata = 32'h11111111;
        cyc();
        idle();
        check_counts("preload", 16'h0, 16'h0);

        // Latency sweep: s2 reads what s1 wrote on the previous edge
        s2_read_check("lat", 10'h010, 32'hDEADBEEF);

        // Read-during-write across ports returns old data
        s1_address = 10'h030; s1_writedata = 32'h22222222; s1_write = 1'b1;
        s2_read_check("rdw_old", 10'h030, 32'h11111111);
        s2_read_check("rdw_new", 10'h030, 32'h22222222);

        // Byte enable: only the top lane is written
        s2_address = 10'h020; s2_writedata = 32'h12345678; s2_byteenable = 4'b1000; s2_write = 1'b1;
        cyc();
        idle();
        s2_read_check("be", 10'h020, 32'h12FFFFFF);

        // Dual-write collision with lane merge
        s1_address = 10'h100; s1_writedata = 32'hAAAAAAAA; s1_byteenable = 4'b0011; s1_write = 1'b1;
        s2_address = 10'h100; s2_writedata = 32'hBBBBBBBB; s2_byteenable = 4'b0110; s2_write = 1'b1;
        cyc();
        idle();
        check_counts("coll1", 16'h1, 16'h1);
        s2_read_check("coll_word", 10'h100, 32'h00BBAAAA);

        // 20 more collisions: 4-bit counter saturates, 16-bit counts on
        s1_address = 10'h200; s1_writedata = 32'h0; s1_write = 1'b1;
        s2_address = 10'h200; s2_writedata = 32'h0; s2_write = 1'b1;
        for (int n = 0; n < 20; n++) cyc();
        idle();
        cyc();
        check_counts("coll_sat", 16'h000F, 16'h0015);

        // Fill 0x40..0x47 from both ports, then 8 back-to-back s1 reads
        for (int i = 0; i < 4; i++) begin
            s1_address = AW'(10'h040 + 2 * i);     s1_writedata = 32'hA0000000 + 32'(2 * i);     s1_write = 1'b1;
            s2_address = AW'(10'h040 + 2 * i + 1); s2_writedata = 32'hA0000000 + 32'(2 * i + 1); s2_write = 1'b1;
            cyc();
        end
        idle();
        for (int s = 1; s <= 10; s++) begin
            if (s <= 8) begin
                s1_address = AW'(10'h040 + s - 1);
                s1_read    = 1'b1;
            end else begin
                s1_read = 1'b0;
            end
            cyc();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("b2b_u%0d_vld_c%0d", d + 1, s), {31'h0, s1_rdv[d]},
                    {31'h0, (s >= d + 1) && (s <= d + 8)});
                if ((s >= d + 1) && (s <= d + 8))
                    chk($sformatf("b2b_u%0d_data_c%0d", d + 1, s), s1_rd[d],
                        32'hA0000000 + 32'(s - d - 1));
            end
        end
        idle();

        // Freeze s1 for 3 edges after a read; s2 read on the same edge runs on
        s1_address = 10'h010; s1_read = 1'b1;
        s2_address = 10'h030; s2_read = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            cyc();
            if (s == 1) begin
                s1_read = 1'b0;
                s2_read = 1'b0;
            end
            if (s == 2) begin
                s1_address = 10'h030;
                s1_read    = 1'b1;
            end
            if (s == 3) s1_read = 1'b0;
            s1_clken = (s <= 3) ? 1'b0 : 1'b1;
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("frz_u%0d_s1vld_c%0d", d + 1, s), {31'h0, s1_rdv[d]},
                    {31'h0, (s == d + 4)});
                if (s == d + 4) chk($sformatf("frz_u%0d_s1data", d + 1), s1_rd[d], 32'hDEADBEEF);
                chk($sformatf("frz_u%0d_s2vld_c%0d", d + 1, s), {31'h0, s2_rdv[d]},
                    {31'h0, (s == d + 1)});
                if (s == d + 1) chk($sformatf("frz_u%0d_s2data", d + 1), s2_rd[d], 32'h22222222);
            end
        end
        idle();
        cyc();

        // Reset in the middle of an in-flight read
        s1_address = 10'h010; s1_read = 1'b1;
        cyc();
        idle();
        reset_n = 1'b0;
        #1;
        check_quiet("rst_mid", 1'b1);
        check_counts("rst_mid", 16'h0, 16'h0);
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            cyc();
            check_quiet($sformatf("rst_after_c%0d", s), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
